// File: rtl/conv_pkg.sv
// Shared definitions for the CONV MAC loop sequencer: default widths,
// controller state encoding and the beat info-word packing helper.
package conv_pkg;

    localparam int TAPW   = 4;
    localparam int GRPW   = 6;
    localparam int POSW   = 10;
    localparam int AW     = 12;
    localparam int INFOW1 = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_e;

    // Info word layout: MSB is the fc flag, the rest is the weights size.
    function automatic logic [INFOW1-1:0] pack_info(input logic fc,
                                                    input logic [INFOW1-2:0] wsize);
        return {fc, wsize};
    endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// Beat stream from the sequencer to the distributer m1_* side.
// The master drives address, markers and info; the slave returns ready.
interface conv_mac_sequencer_if #(
    parameter int AW     = conv_pkg::AW,
    parameter int INFOW1 = conv_pkg::INFOW1
);
    logic [AW-1:0]     fb_addr;
    logic              seq_valid;
    logic              seq_ready;
    logic              seq_first;
    logic              seq_last;
    logic [INFOW1-1:0] seq_info;

    modport master (
        output fb_addr, seq_valid, seq_first, seq_last, seq_info,
        input  seq_ready
    );

    modport slave (
        input  fb_addr, seq_valid, seq_first, seq_last, seq_info,
        output seq_ready
    );
endinterface

// File: rtl/seq_loop_cnt.sv
// Wrap counter for one loop level: counts 0..limit-1 while enabled and
// flags the wrapping step so the next (outer) level can be chained on it.
module seq_loop_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         wrap_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last_o = (cnt_q == (limit_i - W'(1)));
    assign wrap_o = en_i && last_o;
    assign cnt_o  = cnt_q;

    // Next count: clear dominates, otherwise step or wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = last_o ? '0 : cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/conv_mac_sequencer.sv
// CONV MAC loop sequencer for one layer tile. Walks channel groups (inner),
// kernel taps, then output positions, emitting one feature-buffer beat per
// handshake. Optional performance counters are built when SEQ_PERF_CNT_EN
// is defined.
//
// state | meaning
// IDLE  | waiting for cfg_start; zero-size configs rejected here
// RUN   | presenting beats, counters advance on handshake
// FIN   | one-cycle done pulse, then back to IDLE
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int TAPW_P   = TAPW,
    parameter int GRPW_P   = GRPW,
    parameter int POSW_P   = POSW,
    parameter int AW_P     = AW,
    parameter int INFOW1_P = INFOW1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [TAPW_P-1:0]   cfg_taps,
    input  logic [GRPW_P-1:0]   cfg_grps,
    input  logic [POSW_P-1:0]   cfg_npos,
    input  logic [POSW_P-1:0]   cfg_base,
    input  logic [AW_P-1:0]     cfg_addr,
    input  logic [INFOW1_P-1:0] cfg_info,
    conv_mac_sequencer_if.master seq_if,
    output logic [POSW_P-1:0]   acc_base,
    output logic [POSW_P-1:0]   acc_size,
    output logic                busy,
    output logic                done,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]         perf_stall,
    output logic [31:0]         perf_beats,
`endif
    output logic                cfg_err
);
    seq_state_e state_q, state_d;

    logic [TAPW_P-1:0]   taps_q;
    logic [GRPW_P-1:0]   grps_q;
    logic [POSW_P-1:0]   npos_q;
    logic [POSW_P-1:0]   base_q;
    logic [INFOW1_P-1:0] info_q;
    logic [AW_P-1:0]     addr_q;
    logic                err_q;

    logic [GRPW_P-1:0]   grp_cnt;
    logic [TAPW_P-1:0]   tap_cnt;
    logic [POSW_P-1:0]   pos_cnt;
    logic                grp_last, tap_last, pos_last;
    logic                grp_wrap, tap_wrap, pos_wrap;

    logic                start_acc;
    logic                cfg_zero;
    logic                run;
    logic                hs;
    logic                adv;

    assign run       = (state_q == ST_RUN);
    assign start_acc = (state_q == ST_IDLE) && cfg_start;
    assign cfg_zero  = (cfg_taps == '0) || (cfg_grps == '0) || (cfg_npos == '0);
    assign hs        = run && seq_if.seq_ready;
    // Abort wins over a coincident handshake, so the beat is not consumed.
    assign adv       = hs && !cfg_abort;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_start && !cfg_zero) state_d = ST_RUN;
            ST_RUN: begin
                if (cfg_abort)
                    state_d = ST_IDLE;
                else if (pos_wrap)
                    state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Tile configuration latched on start; error flag pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q <= '0;
            grps_q <= '0;
            npos_q <= '0;
            base_q <= '0;
            info_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= start_acc && cfg_zero;
            if (start_acc) begin
                taps_q <= cfg_taps;
                grps_q <= cfg_grps;
                npos_q <= cfg_npos;
                base_q <= cfg_base;
                info_q <= cfg_info;
            end
        end
    end

    // Feature-buffer address: start address plus accepted beats, free wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_q <= '0;
        else if (start_acc)
            addr_q <= cfg_addr;
        else if (adv)
            addr_q <= addr_q + AW_P'(1);
    end

    seq_loop_cnt #(.W(GRPW_P)) u_grp_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_acc),
        .en_i    (adv),
        .limit_i (grps_q),
        .cnt_o   (grp_cnt),
        .last_o  (grp_last),
        .wrap_o  (grp_wrap)
    );

    seq_loop_cnt #(.W(TAPW_P)) u_tap_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_acc),
        .en_i    (grp_wrap),
        .limit_i (taps_q),
        .cnt_o   (tap_cnt),
        .last_o  (tap_last),
        .wrap_o  (tap_wrap)
    );

    seq_loop_cnt #(.W(POSW_P)) u_pos_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_acc),
        .en_i    (tap_wrap),
        .limit_i (npos_q),
        .cnt_o   (pos_cnt),
        .last_o  (pos_last),
        .wrap_o  (pos_wrap)
    );

    assign seq_if.fb_addr   = addr_q;
    assign seq_if.seq_valid = run;
    assign seq_if.seq_first = run && (tap_cnt == '0) && (grp_cnt == '0);
    assign seq_if.seq_last  = run && tap_last && grp_last;
    assign seq_if.seq_info  = info_q;

    assign acc_base = base_q + pos_cnt;
    assign acc_size = npos_q - pos_cnt;
    assign busy     = run;
    assign done     = (state_q == ST_FIN) || err_q;
    assign cfg_err  = err_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] beats_q;

    // Saturating stall/beat counters, cleared by each start and held after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            beats_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
            beats_q <= '0;
        end else if (run) begin
            if (!seq_if.seq_ready && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (seq_if.seq_ready && (beats_q != '1))
                beats_q <= beats_q + 32'd1;
        end
    end

    assign perf_stall = stall_q;
    assign perf_beats = beats_q;
`endif

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer: a table of expected beats for the
// basic tile plus hand-written sequences for backpressure, abort, errors
// and address/base wrap.
module tb_conv_mac_sequencer;
    import conv_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start, cfg_abort;
    logic [TAPW-1:0]   cfg_taps;
    logic [GRPW-1:0]   cfg_grps;
    logic [POSW-1:0]   cfg_npos, cfg_base;
    logic [AW-1:0]     cfg_addr;
    logic [INFOW1-1:0] cfg_info;
    logic [POSW-1:0]   acc_base, acc_size;
    logic              busy, done, cfg_err;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]       perf_stall, perf_beats;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    conv_mac_sequencer_if #(.AW(AW), .INFOW1(INFOW1)) seq_if ();

    conv_mac_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_taps  (cfg_taps),
        .cfg_grps  (cfg_grps),
        .cfg_npos  (cfg_npos),
        .cfg_base  (cfg_base),
        .cfg_addr  (cfg_addr),
        .cfg_info  (cfg_info),
        .seq_if    (seq_if.master),
        .acc_base  (acc_base),
        .acc_size  (acc_size),
        .busy      (busy),
        .done      (done),
`ifdef SEQ_PERF_CNT_EN
        .perf_stall(perf_stall),
        .perf_beats(perf_beats),
`endif
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [AW-1:0]   addr;
        logic            first;
        logic            last;
        logic [POSW-1:0] base;
        logic [POSW-1:0] size;
    } beat_t;

    beat_t basic_tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic chk_beat(input string nm, input beat_t b);
        chk({nm, " valid"}, 32'(seq_if.seq_valid), 32'd1);
        chk({nm, " addr"},  32'(seq_if.fb_addr),   32'(b.addr));
        chk({nm, " first"}, 32'(seq_if.seq_first), 32'(b.first));
        chk({nm, " last"},  32'(seq_if.seq_last),  32'(b.last));
        chk({nm, " base"},  32'(acc_base),         32'(b.base));
        chk({nm, " size"},  32'(acc_size),         32'(b.size));
    endtask

    task automatic start_cfg(input logic [TAPW-1:0] t, input logic [GRPW-1:0] g,
                             input logic [POSW-1:0] n, input logic [POSW-1:0] b,
                             input logic [AW-1:0] a);
        cfg_taps  = t;
        cfg_grps  = g;
        cfg_npos  = n;
        cfg_base  = b;
        cfg_addr  = a;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic chk_done(input string nm);
        chk({nm, " done"},  32'(done),             32'd1);
        chk({nm, " busy"},  32'(busy),             32'd0);
        chk({nm, " valid"}, 32'(seq_if.seq_valid), 32'd0);
        tick();
        chk({nm, " done clr"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [INFOW1-1:0] info_exp;

        // taps=2 grps=3 npos=2 addr=0x100 base=5
        for (int i = 0; i < 12; i++) begin
            basic_tbl[i].addr  = 12'h100 + 12'(i);
            basic_tbl[i].first = 1'b0;
            basic_tbl[i].last  = 1'b0;
            basic_tbl[i].base  = (i < 6) ? 10'd5 : 10'd6;
            basic_tbl[i].size  = (i < 6) ? 10'd2 : 10'd1;
        end
        basic_tbl[0].first  = 1'b1;
        basic_tbl[6].first  = 1'b1;
        basic_tbl[5].last   = 1'b1;
        basic_tbl[11].last  = 1'b1;

        info_exp  = pack_info(1'b1, 10'd300);
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_taps  = '0;
        cfg_grps  = '0;
        cfg_npos  = '0;
        cfg_base  = '0;
        cfg_addr  = '0;
        cfg_info  = info_exp;
        seq_if.seq_ready = 1'b1;
        #12;
        chk("reset valid", 32'(seq_if.seq_valid), 32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        chk("reset done",  32'(done),  32'd0);
        chk("reset err",   32'(cfg_err), 32'd0);
        chk("reset addr",  32'(seq_if.fb_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // abort in IDLE is ignored
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("idle abort busy", 32'(busy), 32'd0);

        // Basic tile, plus a start pulse mid-tile that must be ignored
        start_cfg(4'd2, 6'd3, 10'd2, 10'd5, 12'h100);
        chk("basic busy", 32'(busy), 32'd1);
        chk("basic info", 32'(seq_if.seq_info), 32'(info_exp));
        for (int i = 0; i < 12; i++) begin
            chk_beat($sformatf("basic b%0d", i), basic_tbl[i]);
            if (i == 2) begin
                cfg_start = 1'b1;
                cfg_addr  = 12'h300;
            end
            tick();
            cfg_start = 1'b0;
            cfg_addr  = 12'h100;
        end
        chk_done("basic");

        // Backpressure: ready low for 3 cycles on beat 4
        start_cfg(4'd2, 6'd3, 10'd2, 10'd5, 12'h100);
        for (int i = 0; i < 12; i++) begin
            if (i == 4) begin
                seq_if.seq_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk_beat($sformatf("bp hold%0d", s), basic_tbl[4]);
                    tick();
                end
                seq_if.seq_ready = 1'b1;
            end
            chk_beat($sformatf("bp b%0d", i), basic_tbl[i]);
            tick();
        end
        chk("bp fin valid", 32'(seq_if.seq_valid), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        chk("perf stall", perf_stall, 32'd3);
        chk("perf beats", perf_beats, 32'd12);
`endif
        chk_done("bp");
`ifdef SEQ_PERF_CNT_EN
        chk("perf stall hold", perf_stall, 32'd3);
`endif

        // Degenerate 1x1x1 tile
        start_cfg(4'd1, 6'd1, 10'd1, 10'd7, 12'h020);
        chk_beat("degen", '{addr: 12'h020, first: 1'b1, last: 1'b1, base: 10'd7, size: 10'd1});
        tick();
        chk_done("degen");

        // Zero group count -> error and done, no beats
        start_cfg(4'd2, 6'd0, 10'd2, 10'd5, 12'h100);
        chk("zero err",   32'(cfg_err), 32'd1);
        chk("zero done",  32'(done),    32'd1);
        chk("zero valid", 32'(seq_if.seq_valid), 32'd0);
        chk("zero busy",  32'(busy),    32'd0);
        tick();
        chk("zero err clr",   32'(cfg_err), 32'd0);
        chk("zero done clr",  32'(done),    32'd0);
        chk("zero valid2",    32'(seq_if.seq_valid), 32'd0);

        // Abort on beat 7 with a coincident handshake, then restart
        start_cfg(4'd2, 6'd3, 10'd2, 10'd5, 12'h100);
        for (int i = 0; i < 7; i++)
            tick();
        chk_beat("abort b7", basic_tbl[7]);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("abort valid", 32'(seq_if.seq_valid), 32'd0);
        chk("abort busy",  32'(busy), 32'd0);
        chk("abort done",  32'(done), 32'd0);
        tick();
        chk("abort done2", 32'(done), 32'd0);
        start_cfg(4'd2, 6'd3, 10'd2, 10'd5, 12'h100);
        chk_beat("restart b0", basic_tbl[0]);
        tick();
        chk_beat("restart b1", basic_tbl[1]);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("abort2 busy", 32'(busy), 32'd0);

        // Address and base wrap
        start_cfg(4'd1, 6'd1, 10'd2, 10'd1023, 12'hFFE);
        chk_beat("wrap b0", '{addr: 12'hFFE, first: 1'b1, last: 1'b1, base: 10'd1023, size: 10'd2});
        tick();
        chk_beat("wrap b1", '{addr: 12'hFFF, first: 1'b1, last: 1'b1, base: 10'd0, size: 10'd1});
        tick();
        chk_done("wrap");

        // Reset in the middle of a tile
        start_cfg(4'd2, 6'd3, 10'd2, 10'd5, 12'h100);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(seq_if.seq_valid), 32'd0);
        chk("midrst busy",  32'(busy), 32'd0);
        chk("midrst addr",  32'(seq_if.fb_addr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/conv_mac_sequencer.md
Name: conv_mac_sequencer

Overview:
Loop controller that sequences the CONV MAC datapath for one layer tile. On a start command it walks output positions, kernel taps and input-channel groups. Per beat it emits a feature-buffer address with valid/first/last markers and a beat info word. These drive the m1_* side of the distributer. It also reports the output base/size of each completed accumulation and signals done.

Parameters:
TAPW, 4, width of kernel-tap count (taps = k*k, max 15)
GRPW, 6, width of input-channel-group count (one group = ROW channels)
POSW, 10, width of output-position count and output base
AW, 12, feature-buffer address width
INFOW1, 11, width of beat info word delivered with each beat (fc flag + weights size)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_start  input  1  start pulse; sampled only in IDLE
cfg_abort  input  1  synchronous abort
cfg_taps  input  TAPW  kernel taps per position
cfg_grps  input  GRPW  channel groups per tap
cfg_npos  input  POSW  output positions in tile
cfg_base  input  POSW  first output index
cfg_addr  input  AW  feature-buffer start address
cfg_info  input  INFOW1  fc flag / weights size, latched at start
fb_addr  output  AW  feature-buffer read address for current beat
seq_valid  output  1  beat valid
seq_ready  input  1  downstream accepts beat
seq_first  output  1  first beat of an accumulation
seq_last  output  1  last beat of an accumulation
seq_info  output  INFOW1  latched cfg_info
acc_base  output  POSW  output index of current accumulation
acc_size  output  POSW  positions remaining including current
busy  output  1  tile in progress
done  output  1  one-cycle completion pulse
cfg_err  output  1  one-cycle pulse: zero taps/grps/npos at start

Behaviour:
- Single clock domain: clk. Reset: asynchronous, active-low (rst_n).
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, RUN, FIN.
- IDLE: cfg_start=1 latches all cfg_* fields.
  - Any of taps/grps/npos zero -> cfg_err and done pulse next cycle; stay IDLE; no beats.
  - Otherwise -> RUN. busy=1 and seq_valid=1 from the next cycle (start-to-first-beat latency 1).
- RUN: one beat presented per cycle. Fields stay stable while seq_valid && !seq_ready. Counters advance only on handshake (seq_valid && seq_ready).
- Loop order, innermost first: grp_cnt 0..grps-1, tap_cnt 0..taps-1, pos_cnt 0..npos-1.
- seq_first = (tap_cnt==0 && grp_cnt==0).
- seq_last = (tap_cnt==taps-1 && grp_cnt==grps-1). Both are high on the same beat when taps=grps=1.
- fb_addr = cfg_addr + handshake count; wraps modulo 2^AW with no flag.
- acc_base = cfg_base + pos_cnt, wraps modulo 2^POSW. acc_size = npos - pos_cnt.
- Handshake on the last beat of the last position -> FIN. seq_valid=0 in FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. A new cfg_start is accepted the cycle after FIN.
- cfg_start while busy is ignored.
- cfg_abort in RUN/FIN -> IDLE next cycle: seq_valid=0, busy=0, no done. Abort has priority over a coincident handshake.
- cfg_abort in IDLE is ignored. If cfg_abort and cfg_start are both high in IDLE, start wins.
- Reset mid-tile: immediate return to reset values. No done pulse.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds 32-bit outputs perf_stall (cycles with seq_valid && !seq_ready) and perf_beats (handshakes). Both clear on accepted start, saturate at max, and hold after done.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package conv_pkg: state encoding (IDLE/RUN/FIN), TAPW/GRPW/POSW/AW defaults, and an info-field packing helper for the fc flag and weights size.
- One natural sub-module: seq_loop_cnt, a parameterised wrap counter with enable, limit and wrap-out. It is instantiated three times, chained grp -> tap -> pos.

Test Plan:
- Basic: taps=2, grps=3, npos=2, addr=0x100, base=5, ready=1 -> 12 beats; fb_addr 0x100..0x10B; first on beats 0 and 6, last on beats 5 and 11; acc_base 5 then 6; done 1 cycle after beat 11.
- Backpressure: same config, ready low 3 cycles on beat 4 -> beat-4 fields held 4 cycles; beat total still 12; perf_stall=3 when SEQ_PERF_CNT_EN is defined.
- Degenerate: taps=1, grps=1, npos=1 -> one beat with first=last=1; acc_size=1; done follows.
- Zero config: grps=0 -> cfg_err and done next cycle; seq_valid never high; busy stays 0.
- Abort: abort asserted on beat 7 of the basic config during a handshake -> IDLE next cycle; no done; a fresh start then produces beat 0 at fb_addr=cfg_addr.
- Wrap: addr=0xFFE, base=1023, npos=2, taps=grps=1 -> fb_addr 0xFFE, 0xFFF; acc_base 1023 then 0.
